cb_addr_decoder: RTL and testbench
==================================

// Module: cb_addr_decoder
// PURPOSE
//  Inverse of the CB group base-address generator. Takes a flat covariance-buffer
//  (CB) address and returns the group index and the word offset inside that group.
//  Group k starts at base(k)=2*k*(k+1) and spans 4*(k+1) words.
//  Used by CB readback/debug and by the update engine to map a raw CB address back to (row group, offset).
// PARAMETERS
//  CB_AW      17             CB address width
//  ROW_LEN    10             group index width
//  MAX_GROUP  2**ROW_LEN-1   highest legal group index; addresses above its end set addr_err
// PORTS
//  clk        in   1        system clock, rising edge
//  sys_rst_n  in   1        asynchronous, active-low reset
//  in_valid   in   1        cb_addr valid
//  in_ready   out  1        decoder can accept an address
//  cb_addr    in   CB_AW    CB address to decode
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        consumer accepts the result
//  group_idx  out  ROW_LEN  decoded group k
//  group_off  out  CB_AW    cb_addr - base(k)
//  addr_err   out  1        address beyond MAX_GROUP or CB range; idx/off are don't-care
// BEHAVIOUR
//  Reset (async, sys_rst_n=0):
//   - state=IDLE; in_ready=1.
//   - out_valid=0, group_idx=0, group_off=0, addr_err=0.
//   - Internal regs cleared.
//   - Reset during SEARCH or DONE discards the job. No output follows.
//  FSM IDLE -> SEARCH -> DONE -> IDLE. One job in flight; in_ready=1 only in IDLE.
//  IDLE:
//   - On in_valid&in_ready: latch cb_addr; acc_base=0, stride=4, grp=0; go to SEARCH.
//  SEARCH, one group per cycle:
//   - If addr < acc_base+stride: group_idx=grp, group_off=addr-acc_base, addr_err=0; go to DONE.
//   - Else if grp==MAX_GROUP: addr_err=1; go to DONE.
//   - Else: acc_base+=stride; stride+=4; grp+=1.
//  Widths:
//   - acc_base and the compare sum are CB_AW+1 bits, so there is no wrap.
//   - stride is CB_AW bits.
//   - An address below 2**CB_AW always resolves or errors. It never loops forever.
//  DONE:
//   - out_valid=1. Outputs stay stable while out_ready=0.
//   - On out_ready: out_valid drops next cycle; go to IDLE.
//  Latency: for an address in group k, out_valid rises k+2 cycles after the accepting edge.
//  Throughput: a new accept is possible the cycle after the out_valid/out_ready handshake.
//  in_valid seen outside IDLE is ignored; the producer must hold it.
// STRUCTURE
//  Shared package cb_addr_pkg holds:
//   - CB_AW, ROW_LEN, CB_GROUP_STRIDE=4.
//   - function cb_group_base(k) = 2*k*(k+1), shared with the base generator and the bench model.
//  One natural sub-module, cb_group_step: combinational compare, subtract and next-base/next-stride for one SEARCH iteration.
//  The FSM, handshake and output registers sit in the top.
// TESTING
//  1. cb_addr=0 -> group 0, off 0, no err; out_valid 2 cycles after accept.
//  2. cb_addr=3 -> g0/off3; 4 -> g1/off0 (3 cyc); 23 -> g2/off11; 24 -> g3/off0 (5 cyc).
//  3. CB_AW=17, cb_addr=131071 -> g255/off511, err=0.
//     MAX_GROUP=7, cb_addr=144 -> addr_err=1; cb_addr=143 -> g7/off31.
//  4. Backpressure: out_ready low 4 cycles.
//     - Result stays stable, in_ready=0, second in_valid is not accepted.
//     - Release: IDLE next cycle, then the second job is accepted.
//  5. Reset mid-search: assert sys_rst_n=0 during SEARCH for cb_addr=500.
//     - All outputs 0 and in_ready=1 immediately (async).
//     - No stale out_valid after release.
//  6. Random sweep: 2000 random addresses with random out_ready, checked against cb_group_base.
//     - Scoreboard: every accept yields exactly one result, in order.

Source files
------------

// File: rtl/cb_addr_pkg.sv
// Shared CB addressing definitions: widths, group stride and closed-form base.
// Used by the decoder, the base generator and the bench model.
package cb_addr_pkg;

    localparam int CB_AW           = 17;
    localparam int ROW_LEN         = 10;
    localparam int CB_GROUP_STRIDE = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } cb_dec_state_e;

    function automatic logic [CB_AW:0] cb_group_base(input int unsigned k);
        return (CB_AW+1)'(2 * k * (k + 1));
    endfunction

endpackage

// File: rtl/cb_addr_decoder_if.sv
// Request/response bundle of the CB address decoder.
// master = producer/consumer side, slave = decoder side.
interface cb_addr_decoder_if #(
    parameter int CB_AW   = cb_addr_pkg::CB_AW,
    parameter int ROW_LEN = cb_addr_pkg::ROW_LEN
);

    logic               in_valid;
    logic               in_ready;
    logic [CB_AW-1:0]   cb_addr;
    logic               out_valid;
    logic               out_ready;
    logic [ROW_LEN-1:0] group_idx;
    logic [CB_AW-1:0]   group_off;
    logic               addr_err;

    modport master (
        output in_valid, cb_addr, out_ready,
        input  in_ready, out_valid, group_idx, group_off, addr_err
    );

    modport slave (
        input  in_valid, cb_addr, out_ready,
        output in_ready, out_valid, group_idx, group_off, addr_err
    );

endinterface

// File: rtl/cb_group_step.sv
// One SEARCH iteration: test the current group window and
// produce the base/stride of the following group.
module cb_group_step #(
    parameter int CB_AW     = cb_addr_pkg::CB_AW,
    parameter int ROW_LEN   = cb_addr_pkg::ROW_LEN,
    parameter int MAX_GROUP = (1 << ROW_LEN) - 1
) (
    input  logic [CB_AW-1:0]   addr,
    input  logic [CB_AW:0]     base,
    input  logic [CB_AW-1:0]   stride,
    input  logic [ROW_LEN-1:0] grp,
    output logic               hit,
    output logic               last,
    output logic [CB_AW-1:0]   off,
    output logic [CB_AW:0]     next_base,
    output logic [CB_AW-1:0]   next_stride
);
    import cb_addr_pkg::*;

    // One extra bit keeps the window end from wrapping near the top of CB.
    logic [CB_AW:0] sum;

    assign sum         = base + {1'b0, stride};
    assign hit         = {1'b0, addr} < sum;
    assign off         = CB_AW'({1'b0, addr} - base);
    assign next_base   = sum;
    assign next_stride = stride + CB_AW'(CB_GROUP_STRIDE);
    assign last        = grp == ROW_LEN'(MAX_GROUP);

endmodule

// File: rtl/cb_addr_decoder.sv
// Maps a flat CB address back to (group, offset) by walking the
// group windows one per cycle.
module cb_addr_decoder #(
    parameter int CB_AW     = cb_addr_pkg::CB_AW,
    parameter int ROW_LEN   = cb_addr_pkg::ROW_LEN,
    parameter int MAX_GROUP = (1 << ROW_LEN) - 1
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    cb_addr_decoder_if.slave bus
);
    import cb_addr_pkg::*;

    cb_dec_state_e      state_q, state_d;
    logic [CB_AW-1:0]   addr_q;
    logic [CB_AW:0]     base_q;
    logic [CB_AW-1:0]   stride_q;
    logic [ROW_LEN-1:0] grp_q;
    logic [ROW_LEN-1:0] idx_q;
    logic [CB_AW-1:0]   off_q;
    logic               err_q;
    logic               ov_q;

    logic               hit;
    logic               last;
    logic [CB_AW-1:0]   off_c;
    logic [CB_AW:0]     nbase;
    logic [CB_AW-1:0]   nstride;

    logic               load;
    logic               step;
    logic               resolve;
    logic               fail;
    logic               hs;

    cb_group_step #(
        .CB_AW     (CB_AW),
        .ROW_LEN   (ROW_LEN),
        .MAX_GROUP (MAX_GROUP)
    ) u_step (
        .addr        (addr_q),
        .base        (base_q),
        .stride      (stride_q),
        .grp         (grp_q),
        .hit         (hit),
        .last        (last),
        .off         (off_c),
        .next_base   (nbase),
        .next_stride (nstride)
    );

    assign hs = ov_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        resolve = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (hit) begin
                    resolve = 1'b1;
                    state_d = ST_DONE;
                end else if (last) begin
                    resolve = 1'b1;
                    fail    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                if (hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            grp_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            err_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Result is presented one cycle after entering DONE.
            ov_q    <= (state_q == ST_DONE) && !hs;
            if (load) begin
                addr_q   <= bus.cb_addr;
                base_q   <= '0;
                stride_q <= CB_AW'(CB_GROUP_STRIDE);
                grp_q    <= '0;
            end
            if (step) begin
                base_q   <= nbase;
                stride_q <= nstride;
                grp_q    <= grp_q + 1'b1;
            end
            if (resolve) begin
                idx_q <= grp_q;
                off_q <= off_c;
                err_q <= fail;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = ov_q;
    assign bus.group_idx = idx_q;
    assign bus.group_off = off_q;
    assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_cb_addr_decoder.sv
// Bench for cb_addr_decoder: directed vectors plus a per-cycle
// model check of handshake, latency and decoded result.
module tb_cb_addr_decoder;
    import cb_addr_pkg::*;

    typedef struct {
        int a;
        int g;
        int off;
        bit err;
        int lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   acc_cyc;
    int   acc_cnt;
    int   res_cnt;
    bit   busy;
    int   rdy_mode;
    exp_t q[$];

    cb_addr_decoder_if #(.CB_AW(17), .ROW_LEN(10)) bus ();
    cb_addr_decoder_if #(.CB_AW(17), .ROW_LEN(10)) bus7 ();

    cb_addr_decoder #(.CB_AW(17), .ROW_LEN(10)) dut (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    cb_addr_decoder #(.CB_AW(17), .ROW_LEN(10), .MAX_GROUP(7)) dut7 (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (bus7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: smallest k whose window [base(k), base(k+1)) holds a.
    function automatic void model(input int a, input int maxg, output exp_t e);
        int k;
        k = 0;
        while (k <= maxg && int'(cb_group_base(k + 1)) <= a) k++;
        e.a = a;
        if (k > maxg) begin
            e.err = 1'b1;
            e.g   = maxg;
            e.off = 0;
        end else begin
            e.err = 1'b0;
            e.g   = k;
            e.off = a - int'(cb_group_base(k));
        end
        e.lat = e.g + 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        bit   exp_ov;
        if (!rst_n) begin
            q.delete();
            busy = 1'b0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(!busy));
            exp_ov = busy && q.size() > 0 && (cyc - acc_cyc >= q[0].lat);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (bus.out_valid && exp_ov) begin
                chk("addr_err", 32'(bus.addr_err), 32'(q[0].err));
                if (!q[0].err) begin
                    chk("group_idx", 32'(bus.group_idx), 32'(q[0].g));
                    chk("group_off", 32'(bus.group_off), 32'(q[0].off));
                end
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    busy = 1'b0;
                    res_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model(int'(bus.cb_addr), 1023, e);
                q.push_back(e);
                busy    = 1'b1;
                acc_cyc = cyc + 1;
                acc_cnt++;
            end
        end
    end

    task automatic send(input int a);
        int n;
        n = 0;
        bus.cb_addr  = 17'(a);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input int a, input int g, input int off, input int lat);
        int n;
        send(a);
        n = 0;
        while (!bus.out_valid && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk($sformatf("lat_%0d", a), 32'(n), 32'(lat));
        chk($sformatf("idx_%0d", a), 32'(bus.group_idx), 32'(g));
        chk($sformatf("off_%0d", a), 32'(bus.group_off), 32'(off));
        chk($sformatf("err_%0d", a), 32'(bus.addr_err), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run7(input int a, input bit err, input int g, input int off);
        int n;
        n = 0;
        bus7.cb_addr  = 17'(a);
        bus7.in_valid = 1'b1;
        @(posedge clk);
        #1 bus7.in_valid = 1'b0;
        while (!bus7.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk($sformatf("m7_lat_%0d", a), 32'(n), 32'(9));
        chk($sformatf("m7_err_%0d", a), 32'(bus7.addr_err), 32'(err));
        if (!err) begin
            chk($sformatf("m7_idx_%0d", a), 32'(bus7.group_idx), 32'(g));
            chk($sformatf("m7_off_%0d", a), 32'(bus7.group_off), 32'(off));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   a;
        logic [9:0]  h_idx;
        logic [16:0] h_off;
        bit   stale;

        checks        = 0;
        errors        = 0;
        cyc           = 0;
        acc_cyc       = 0;
        acc_cnt       = 0;
        res_cnt       = 0;
        busy          = 1'b0;
        rdy_mode      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.cb_addr   = '0;
        bus.out_ready = 1'b1;
        bus7.in_valid = 1'b0;
        bus7.cb_addr  = '0;
        bus7.out_ready = 1'b1;

        // Model pinned against hand-computed values.
        model(23, 1023, e);
        chk("model_g_23", 32'(e.g), 32'(2));
        chk("model_off_23", 32'(e.off), 32'(11));
        model(131071, 1023, e);
        chk("model_g_131071", 32'(e.g), 32'(255));
        chk("model_off_131071", 32'(e.off), 32'(511));
        model(144, 7, e);
        chk("model_err_144", 32'(e.err), 32'(1));

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_group_idx", 32'(bus.group_idx), 32'(0));
        chk("rst_group_off", 32'(bus.group_off), 32'(0));
        chk("rst_addr_err", 32'(bus.addr_err), 32'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(0, 0, 0, 2);
        run_one(3, 0, 3, 2);
        run_one(4, 1, 0, 3);
        run_one(23, 2, 11, 4);
        run_one(24, 3, 0, 5);
        run_one(131071, 255, 511, 257);

        run7(144, 1'b1, 0, 0);
        run7(143, 1'b0, 7, 31);

        // Backpressure: result held, second request parked.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(100);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_lat", 32'(n), 32'(8));
        h_idx = bus.group_idx;
        h_off = bus.group_off;
        chk("bp_idx", 32'(h_idx), 32'(6));
        chk("bp_off", 32'(h_off), 32'(16));
        bus.cb_addr  = 17'd50;
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #2;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'(1));
            chk("bp_hold_idx", 32'(bus.group_idx), 32'(h_idx));
            chk("bp_hold_off", 32'(bus.group_off), 32'(h_off));
            chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
        end
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("bp_release_valid", 32'(bus.out_valid), 32'(0));
        chk("bp_release_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        chk("bp_second_taken", 32'(bus.in_ready), 32'(0));
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp2_idx", 32'(bus.group_idx), 32'(4));
        chk("bp2_off", 32'(bus.group_off), 32'(10));
        @(posedge clk);
        #1;

        // Reset in the middle of a search.
        send(500);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("mid_rst_idx", 32'(bus.group_idx), 32'(0));
        chk("mid_rst_off", 32'(bus.group_off), 32'(0));
        chk("mid_rst_err", 32'(bus.addr_err), 32'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stale = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no_stale_result", 32'(stale), 32'(0));

        // Random sweep with random consumer stalls.
        rdy_mode = 1;
        acc_cnt  = 0;
        res_cnt  = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 199) a = int'($urandom_range(0, 131071));
            else                a = int'($urandom_range(0, 2047));
            send(a);
        end
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(busy), 32'(0));
        chk("accepts_2000", 32'(acc_cnt), 32'(2000));
        chk("results_match_accepts", 32'(res_cnt), 32'(acc_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
